seg_display_reader: RTL and testbench

Capture-side counterpart to the frequency counter's multiplexed seven-segment output. It watches the `segments` / `digit` pins, waits for each digit phase to settle, and decodes the glyph back to BCD. It pairs a tens and a units digit into one 0–99 reading and presents it with a one-cycle `valid` strobe. Used in-bench and on-chip for loopback self-test of the display path.

---
 rtl/seg_display_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 22 ++
 rtl/seg_display_reader.sv | 135 +++++++++++++
 tb/tb_seg_display_reader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants and types for the seven-segment capture path.
package seg_display_pkg;

    // Glyphs, active high, bit0=a ... bit6=g
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // Decode table, indexed by the BCD digit it represents
    localparam logic [9:0][6:0] SEG_TABLE = {SEG_9, SEG_8, SEG_7, SEG_6, SEG_5,
                                             SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        HOLD   = 2'd1,
        EMIT   = 2'd2
    } state_e;

    // One captured digit slot (tens or units)
    typedef struct packed {
        logic       have;
        logic       bad;
        logic [3:0] bcd;
    } slot_t;

endpackage

// File: rtl/seg7_decode.sv
// Glyph to BCD decoder; unknown glyphs (including blank) map to 0 and flag illegal.
module seg7_decode
    import seg_display_pkg::*;
(
    input  logic [6:0] glyph,
    output logic [3:0] bcd,
    output logic       illegal
);

    // Table search: at most one entry can match since all glyphs are distinct
    always_comb begin
        bcd     = 4'd0;
        illegal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (glyph == SEG_TABLE[i]) begin
                bcd     = 4'(i);
                illegal = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_display_reader.sv
// Samples the multiplexed seven-segment pins once per settled phase and
// pairs tens/units captures into a 0-99 reading with a one-cycle strobe.
module seg_display_reader
    import seg_display_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] segments,
    input  logic       digit,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] value,
    output logic       valid,
    output logic       err,
    output logic [1:0] state
);

    localparam logic [7:0] THRESH = 8'(STABLE_CYCLES);

    logic [7:0] cur_in;
    logic       changed;
    logic [7:0] prev_q, prev_d;
    logic [7:0] cnt_q, cnt_d;
    state_e     state_q, state_d;
    slot_t      tens_slot_q, tens_slot_d;
    slot_t      units_slot_q, units_slot_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] units_q, units_d;
    logic [6:0] value_q, value_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [3:0] dec_bcd;
    logic       dec_bad;
    logic [6:0] t_ext, u_ext;

    // One decoder serves both slots; only the current phase is ever captured
    seg7_decode u_dec (
        .glyph   (segments),
        .bcd     (dec_bcd),
        .illegal (dec_bad)
    );

    // Change detection and saturating stability counter
    always_comb begin
        cur_in  = {digit, segments};
        changed = (cur_in != prev_q);
        prev_d  = cur_in;
        if (changed) begin
            cnt_d = 8'd0;
        end else if (cnt_q >= THRESH) begin
            cnt_d = THRESH;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // FSM next-state, slot capture and pair emission
    always_comb begin
        state_d      = state_q;
        tens_slot_d  = tens_slot_q;
        units_slot_d = units_slot_q;
        tens_d       = tens_q;
        units_d      = units_q;
        value_d      = value_q;
        err_d        = err_q;
        valid_d      = 1'b0;
        t_ext        = {3'b000, tens_slot_q.bcd};
        u_ext        = {3'b000, units_slot_q.bcd};
        case (state_q)
            SETTLE: begin
                // A change on the threshold cycle wins: no capture
                if (!changed && cnt_d == THRESH) begin
                    if (digit) begin
                        tens_slot_d = '{have: 1'b1, bad: dec_bad, bcd: dec_bcd};
                        state_d     = units_slot_q.have ? EMIT : HOLD;
                    end else begin
                        units_slot_d = '{have: 1'b1, bad: dec_bad, bcd: dec_bcd};
                        state_d      = tens_slot_q.have ? EMIT : HOLD;
                    end
                end
            end
            HOLD: begin
                if (changed) state_d = SETTLE;
            end
            EMIT: begin
                valid_d           = 1'b1;
                tens_d            = tens_slot_q.bcd;
                units_d           = units_slot_q.bcd;
                value_d           = (t_ext << 3) + (t_ext << 1) + u_ext;
                err_d             = tens_slot_q.bad | units_slot_q.bad;
                tens_slot_d.have  = 1'b0;
                units_slot_d.have = 1'b0;
                state_d           = changed ? SETTLE : HOLD;
            end
            default: state_d = SETTLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q       <= '0;
            cnt_q        <= '0;
            state_q      <= SETTLE;
            tens_slot_q  <= '0;
            units_slot_q <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            value_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            tens_slot_q  <= tens_slot_d;
            units_slot_q <= units_slot_d;
            tens_q       <= tens_d;
            units_q      <= units_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign tens  = tens_q;
    assign units = units_q;
    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign state = state_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed plus randomized bench for seg_display_reader against a run-length model.
module tb_seg_display_reader;

    localparam int S = 4;
    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] segments = '0;
    logic       digit = 1'b0;
    logic [3:0] tens, units;
    logic [6:0] value;
    logic       valid, err;
    logic [1:0] state;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    logic [7:0] m_prev;
    int         m_run;
    bit         m_have [2];
    int         m_val  [2];
    bit         m_bad  [2];
    bit         m_pend, m_valid, m_err;
    int         m_t, m_u, m_v;

    // observed strobes
    int vcnt;
    int lv_t, lv_u, lv_v, lv_e;

    seg_display_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .segments(segments), .digit(digit),
        .tens(tens), .units(units), .value(value), .valid(valid),
        .err(err), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // A phase is captured once, when it has matched the previous sample S times in a row
    task automatic model_edge(input logic r, input logic [7:0] v);
        int d;
        if (!r) begin
            m_prev = '0; m_run = 0; m_pend = 0; m_valid = 0;
            m_have = '{0, 0}; m_bad = '{0, 0}; m_val = '{0, 0};
            m_t = 0; m_u = 0; m_v = 0; m_err = 0;
        end else begin
            if (v == m_prev) m_run++; else m_run = 0;
            m_prev  = v;
            m_valid = 0;
            if (m_pend) begin
                m_valid = 1;
                m_t = m_val[1]; m_u = m_val[0];
                m_v = m_t * 10 + m_u;
                m_err = m_bad[0] | m_bad[1];
                m_have = '{0, 0};
                m_pend = 0;
            end
            if (m_run == S) begin
                d = int'(v[7]);
                m_val[d] = 0; m_bad[d] = 1;
                for (int i = 0; i < 10; i++)
                    if (v[6:0] == GLYPH[i]) begin m_val[d] = i; m_bad[d] = 0; end
                m_have[d] = 1;
                if (m_have[0] && m_have[1]) m_pend = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic d, input logic [6:0] s);
        rst_n = r; digit = d; segments = s;
        @(posedge clk);
        model_edge(r, {d, s});
        #1;
        chk("valid", {31'b0, valid}, m_valid);
        chk("state_emit", {31'b0, state == 2'd2}, m_pend);
        chk("tens", {28'b0, tens}, m_t);
        chk("units", {28'b0, units}, m_u);
        chk("value", {25'b0, value}, m_v);
        chk("err", {31'b0, err}, m_err);
        if (valid === 1'b1) begin
            vcnt++; lv_t = tens; lv_u = units; lv_v = value; lv_e = err;
        end
    endtask

    task automatic hold(input logic d, input logic [6:0] s, input int n);
        repeat (n) step(1'b1, d, s);
    endtask

    initial begin
        logic       r, d;
        logic [6:0] s;
        int         len;

        // reset
        step(1'b0, 1'b0, 7'h00);
        step(1'b0, 1'b0, 7'h00);
        chk("rst_tens", {28'b0, tens}, 0);
        chk("rst_units", {28'b0, units}, 0);
        chk("rst_value", {25'b0, value}, 0);
        chk("rst_valid", {31'b0, valid}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_state", {30'b0, state}, 0);

        // units 2, tens 4: strobe 6 cycles into the tens phase
        vcnt = 0;
        hold(1'b0, 7'h5B, 10);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 1'b1, 7'h66);
            if (i == 5) chk("s1_state5", {30'b0, state}, 2);
            if (i == 6) begin
                chk("s1_valid6", {31'b0, valid}, 1);
                chk("s1_value", {25'b0, value}, 42);
                chk("s1_tens", {28'b0, tens}, 4);
                chk("s1_units", {28'b0, units}, 2);
                chk("s1_err", {31'b0, err}, 0);
            end
        end
        chk("s1_count", vcnt, 1);

        // 3-cycle phases never settle
        vcnt = 0;
        repeat (6) begin
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 1'b0, 7'h6D);
                chk("s2_state", {30'b0, state}, 0);
            end
            for (int i = 0; i < 3; i++) begin
                step(1'b1, 1'b1, 7'h3F);
                chk("s2_state", {30'b0, state}, 0);
            end
        end
        chk("s2_count", vcnt, 0);

        // blank units, tens 8 -> 80 with err
        vcnt = 0;
        hold(1'b0, 7'h00, 8);
        hold(1'b1, 7'h7F, 8);
        chk("s3_count", vcnt, 1);
        chk("s3_value", lv_v, 80);
        chk("s3_units", lv_u, 0);
        chk("s3_err", lv_e, 1);

        // units overwritten 9 -> 1, then tens 1 -> 11
        vcnt = 0;
        hold(1'b0, 7'h6F, 8);
        hold(1'b0, 7'h06, 8);
        hold(1'b1, 7'h06, 8);
        chk("s4_count", vcnt, 1);
        chk("s4_value", lv_v, 11);

        // reset discards a half pair
        vcnt = 0;
        hold(1'b0, 7'h7D, 8);
        step(1'b0, 1'b1, 7'h3F);
        hold(1'b1, 7'h3F, 10);
        chk("s5_nostrobe", vcnt, 0);
        hold(1'b0, 7'h07, 10);
        chk("s5_count", vcnt, 1);
        chk("s5_value", lv_v, 7);

        // tens first then units; long tens hold yields no second strobe
        vcnt = 0;
        hold(1'b1, 7'h06, 8);
        hold(1'b0, 7'h3F, 8);
        hold(1'b1, 7'h06, 50);
        chk("s6_count", vcnt, 1);
        chk("s6_value", lv_v, 10);

        // random phases, lengths around the threshold, occasional reset
        for (int k = 0; k < 250; k++) begin
            r   = ($urandom_range(0, 39) != 0);
            d   = 1'($urandom_range(0, 1));
            s   = ($urandom_range(0, 3) != 0) ? GLYPH[$urandom_range(0, 9)] : 7'($urandom);
            len = $urandom_range(1, 8);
            if (!r) step(1'b0, d, s);
            else    hold(d, s, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
